// File: rtl/psram_async_ctrl_if.sv
// Request/response handshake and CellularRAM pin bundle for psram_async_ctrl.
// slave = controller view; master = requester plus board/pad view.
interface psram_async_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_cfg;
    logic [22:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        mem_clk;
    logic        mem_adv_n;
    logic        mem_cre;
    logic        mem_ce_n;
    logic        mem_oe_n;
    logic        mem_we_n;
    logic [1:0]  mem_be;
    logic [22:0] mem_addr;
    logic [15:0] mem_dq_o;
    logic        mem_dq_oe;
    logic [15:0] mem_dq_i;
    logic        mem_wait;

    modport slave (
        input  req_valid, req_we, req_cfg, req_addr, req_wdata, req_be, mem_dq_i, mem_wait,
        output req_ready, rsp_valid, rsp_rdata, mem_clk, mem_adv_n, mem_cre, mem_ce_n,
               mem_oe_n, mem_we_n, mem_be, mem_addr, mem_dq_o, mem_dq_oe
    );

    modport master (
        output req_valid, req_we, req_cfg, req_addr, req_wdata, req_be, mem_dq_i, mem_wait,
        input  req_ready, rsp_valid, rsp_rdata, mem_clk, mem_adv_n, mem_cre, mem_ce_n,
               mem_oe_n, mem_we_n, mem_be, mem_addr, mem_dq_o, mem_dq_oe
    );
endinterface

// File: rtl/psram_async_ctrl.sv
// Asynchronous-mode CellularRAM controller: single-word read, write and CRE config write.
// Every output is registered from next-state values, so strobes are glitch-free.
module psram_async_ctrl #(
    parameter int unsigned INIT_CYCLES = 12000,
    parameter int unsigned T_RD        = 6,
    parameter int unsigned T_WR        = 6,
    parameter int unsigned T_REC       = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    psram_async_ctrl_if.slave bus
);

    typedef enum logic [2:0] {StInit, StIdle, StRd, StWr, StCfg, StRec} state_e;

    localparam logic [15:0] InitLast = 16'(INIT_CYCLES - 1);
    localparam logic [7:0]  RdLast   = 8'(T_RD - 1);
    localparam logic [7:0]  WrLast   = 8'(T_WR - 1);
    localparam logic [7:0]  RecLast  = 8'(T_REC - 1);

    state_e      state_q, state_d;
    logic [15:0] init_cnt_q, init_cnt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        accept;

    logic        ready_q, ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        we_n_q, we_n_d;
    logic        adv_n_q, adv_n_d;
    logic        cre_q, cre_d;
    logic [1:0]  be_q, be_d;
    logic [22:0] addr_q, addr_d;
    logic [15:0] dq_o_q, dq_o_d;
    logic        dq_oe_q, dq_oe_d;
    logic        strobe;

    logic unused_wait;
    assign unused_wait = bus.mem_wait;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        unique case (state_q)
            StInit: begin
                if (init_cnt_q == InitLast) state_d = StIdle;
                else                        init_cnt_d = init_cnt_q + 16'd1;
            end
            StIdle: begin
                if (bus.req_valid && ready_q) begin
                    accept = 1'b1;
                    if (bus.req_cfg) begin
                        state_d = StCfg;
                        cnt_d   = WrLast;
                    end else if (bus.req_we) begin
                        state_d = StWr;
                        cnt_d   = WrLast;
                    end else begin
                        state_d = StRd;
                        cnt_d   = RdLast;
                    end
                end
            end
            StRd, StWr, StCfg: begin
                if (cnt_q == 8'd0) begin
                    state_d = StRec;
                    cnt_d   = RecLast;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StRec: begin
                if (cnt_q == 8'd0) state_d = StIdle;
                else               cnt_d = cnt_q - 8'd1;
            end
            default: state_d = StInit;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_comb begin
        strobe      = (state_d == StRd) || (state_d == StWr) || (state_d == StCfg);
        ce_n_d      = !strobe;
        adv_n_d     = !strobe;
        oe_n_d      = (state_d != StRd);
        we_n_d      = !((state_d == StWr) || (state_d == StCfg));
        cre_d       = (state_d == StCfg);
        // Keep driving write data for one recovery cycle as hold time.
        dq_oe_d     = (state_d == StWr) || ((state_d == StRec) && (state_q == StWr));
        ready_d     = (state_d == StIdle);
        rsp_valid_d = (state_d == StRec) && (state_q != StRec);
        rdata_d     = rdata_q;
        if ((state_q == StRd) && (cnt_q == 8'd0)) rdata_d = bus.mem_dq_i;
        addr_d = addr_q;
        be_d   = be_q;
        dq_o_d = dq_o_q;
        if (accept) begin
            addr_d = bus.req_addr;
            be_d   = bus.req_cfg ? 2'b11 : ~bus.req_be;
            if (!bus.req_cfg && bus.req_we) dq_o_d = bus.req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StInit;
            init_cnt_q  <= 16'd0;
            cnt_q       <= 8'd0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 16'd0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            adv_n_q     <= 1'b1;
            cre_q       <= 1'b0;
            be_q        <= 2'b11;
            addr_q      <= 23'd0;
            dq_o_q      <= 16'd0;
            dq_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            adv_n_q     <= adv_n_d;
            cre_q       <= cre_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.mem_clk   = 1'b0;
    assign bus.mem_adv_n = adv_n_q;
    assign bus.mem_cre   = cre_q;
    assign bus.mem_ce_n  = ce_n_q;
    assign bus.mem_oe_n  = oe_n_q;
    assign bus.mem_we_n  = we_n_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_dq_o  = dq_o_q;
    assign bus.mem_dq_oe = dq_oe_q;

endmodule
